ft_host_cmd_packer: RTL and testbench

Host-side command packetizer for the FT245 sync-FIFO link. Accepts one command descriptor plus an optional stream of write data, and serializes it into the 32-bit word stream that the device-side host interface parses: header word, address word, then data words. Sits in front of the outbound 32-bit FIFO that feeds the FTDI PHY in host-emulation and loopback builds.

---
 rtl/ft_host_pkg.sv | 36 +++
 rtl/ft_host_cmd_packer.sv | 133 +++++++++++++
 tb/tb_ft_host_cmd_packer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_host_pkg.sv
// Shared definitions for the FT245 host command packetizer: command
// nibbles, FSM state encoding and header word layout.
package ft_host_pkg;

  localparam logic [3:0] CMD_PING  = 4'h0;
  localparam logic [3:0] CMD_WRITE = 4'h1;
  localparam logic [3:0] CMD_READ  = 4'h2;

  // Header word layout: [31:24] command byte, [23:0] word count.
  localparam int HDR_CMD_MSB = 31;
  localparam int HDR_CMD_LSB = 24;
  localparam int HDR_CNT_MSB = 23;
  localparam int HDR_CNT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_ADDRESS = 2'd2,
    ST_DATA    = 2'd3
  } state_t;

  // Only ping, write and read produce a packet; every other nibble is rejected.
  function automatic logic cmd_known(input logic [3:0] nibble);
    return (nibble == CMD_PING) || (nibble == CMD_WRITE) || (nibble == CMD_READ);
  endfunction

  function automatic logic [31:0] make_header(input logic [7:0] command,
                                              input logic [23:0] count);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_CMD_MSB:HDR_CMD_LSB] = command;
    hdr[HDR_CNT_MSB:HDR_CNT_LSB] = count;
    return hdr;
  endfunction

endpackage

// File: rtl/ft_host_cmd_packer.sv
// Serializes one command descriptor (plus optional write data) into the
// header / address / data word stream consumed by the device-side parser.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a descriptor; unknown nibbles rejected here
// ST_HEADER  | presenting {command, count}; ping sends a zero count
// ST_ADDRESS | presenting the latched address (read/write only)
// ST_DATA    | passing write data through until remaining reaches zero
module ft_host_cmd_packer
  import ft_host_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_command,
  input  logic [31:0] cmd_address,
  input  logic [23:0] cmd_data_count,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [31:0] data,
  input  logic        fifo_full,
  output logic        fifo_wr,
  output logic [31:0] fifo_data,
  output logic        pkt_done,
  output logic        cmd_error
);

  state_t      state;
  logic [7:0]  cmd_q;
  logic [31:0] addr_q;
  logic [23:0] count_q;
  logic [23:0] remaining;
  logic        is_ping;
  logic        is_write;
  logic        accept;

  assign is_ping   = (cmd_q[3:0] == CMD_PING);
  assign is_write  = (cmd_q[3:0] == CMD_WRITE);
  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  // Word mux and handshakes; the FIFO never sees a strobe while it is full.
  always_comb begin
    fifo_wr    = 1'b0;
    fifo_data  = '0;
    data_ready = 1'b0;
    case (state)
      ST_HEADER: begin
        fifo_wr   = ~fifo_full;
        fifo_data = make_header(cmd_q, is_ping ? 24'h0 : count_q);
      end
      ST_ADDRESS: begin
        fifo_wr   = ~fifo_full;
        fifo_data = addr_q;
      end
      ST_DATA: begin
        data_ready = ~fifo_full;
        fifo_wr    = data_valid & ~fifo_full;
        fifo_data  = data;
      end
      default: begin
        fifo_wr = 1'b0;
      end
    endcase
  end

  // Packet sequencing, field latching and the one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      remaining <= '0;
      pkt_done  <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      pkt_done  <= 1'b0;
      cmd_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q   <= cmd_command;
            addr_q  <= cmd_address;
            count_q <= cmd_data_count;
            if (cmd_known(cmd_command[3:0])) begin
              state <= ST_HEADER;
            end else begin
              cmd_error <= 1'b1;
            end
          end
        end
        ST_HEADER: begin
          if (fifo_wr) begin
            if (is_ping) begin
              state    <= ST_IDLE;
              pkt_done <= 1'b1;
            end else begin
              state <= ST_ADDRESS;
            end
          end
        end
        ST_ADDRESS: begin
          if (fifo_wr) begin
            if (is_write && (count_q != 24'h0)) begin
              state     <= ST_DATA;
              remaining <= count_q;
            end else begin
              state    <= ST_IDLE;
              pkt_done <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          // remaining is at least 1 here, so the decrement cannot wrap.
          if (fifo_wr) begin
            remaining <= remaining - 24'd1;
            if (remaining == 24'd1) begin
              state    <= ST_IDLE;
              pkt_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft_host_cmd_packer.sv
// Bench for ft_host_cmd_packer: directed packets from the test plan followed
// by randomized packets, each compared against a word-list reference model.
module tb_ft_host_cmd_packer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_command;
  logic [31:0] cmd_address;
  logic [23:0] cmd_data_count;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data;
  logic        fifo_full;
  logic        fifo_wr;
  logic [31:0] fifo_data;
  logic        pkt_done;
  logic        cmd_error;

  int checks = 0;
  int errors = 0;
  logic [31:0] got_q[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int dr_cnt   = 0;
  logic prev_wr = 1'b0;

  ft_host_cmd_packer dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_command    (cmd_command),
    .cmd_address    (cmd_address),
    .cmd_data_count (cmd_data_count),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .data           (data),
    .fifo_full      (fifo_full),
    .fifo_wr        (fifo_wr),
    .fifo_data      (fifo_data),
    .pkt_done       (pkt_done),
    .cmd_error      (cmd_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: collects every word the FIFO accepts and the status pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (fifo_wr === 1'b1) begin
          chk("wr_while_full", {31'h0, fifo_full}, 32'h0);
          got_q.push_back(fifo_data);
        end
        if (pkt_done === 1'b1) begin
          done_cnt++;
          chk("pkt_done_after_last_write", {31'h0, prev_wr}, 32'h1);
        end
        if (cmd_error === 1'b1) err_cnt++;
        if (data_ready === 1'b1) dr_cnt++;
        prev_wr = fifo_wr;
      end else begin
        prev_wr = 1'b0;
      end
    end
  end

  // One packet: build the expected word list, drive it through, compare.
  task automatic do_packet(input string tag, input logic [7:0] c, input logic [31:0] a,
                           input logic [23:0] n, input int full_pct, input int gap_pct,
                           input int stall_addr, input int stall_data, input int abort_at);
    logic [31:0] exp_q[$];
    logic [31:0] wdata[$];
    int nib, cnt, widx, budget, cycles, base_done, base_err, base_dr;
    int sa, sd;
    bit accepted, xfer, finished, aborted;

    nib = int'(c[3:0]);
    cnt = int'(n);
    sa = stall_addr;
    sd = stall_data;
    exp_q = {};
    wdata = {};
    if (nib <= 2) begin
      exp_q.push_back({c, (nib == 0) ? 24'h0 : n});
      if (nib != 0) exp_q.push_back(a);
      if (nib == 1) begin
        for (int i = 0; i < cnt; i++) begin
          wdata.push_back($urandom);
          exp_q.push_back(wdata[i]);
        end
      end
    end

    got_q = {};
    base_done = done_cnt;
    base_err  = err_cnt;
    base_dr   = dr_cnt;

    cmd_valid      = 1'b1;
    cmd_command    = c;
    cmd_address    = a;
    cmd_data_count = n;
    budget = 50;
    accepted = 1'b0;
    while (!accepted && budget > 0) begin
      accepted = cmd_ready;
      @(posedge clk); #1;
      budget--;
    end
    chk({tag, "_accept"}, {31'h0, accepted}, 32'h1);
    cmd_valid      = 1'b0;
    cmd_command    = 8'($urandom);
    cmd_address    = $urandom;
    cmd_data_count = 24'($urandom);

    widx = 0;
    cycles = 0;
    budget = 600;
    finished = 1'b0;
    aborted = 1'b0;
    while (!finished && budget > 0) begin
      if (abort_at > 0 && got_q.size() == abort_at) begin
        fifo_full  = 1'b0;
        data_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk({tag, "_rst_fifo_wr"},    {31'h0, fifo_wr},    32'h0);
        chk({tag, "_rst_cmd_ready"},  {31'h0, cmd_ready},  32'h1);
        chk({tag, "_rst_data_ready"}, {31'h0, data_ready}, 32'h0);
        chk({tag, "_rst_fifo_data"},  fifo_data,           32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1'b1;
        finished = 1'b1;
      end else begin
        if (sa > 0 && got_q.size() == 1) begin
          fifo_full = 1'b1;
          sa--;
        end else if (sd > 0 && got_q.size() == 3) begin
          fifo_full = 1'b1;
          sd--;
        end else begin
          fifo_full = ($urandom_range(99) < full_pct);
        end
        if (widx < wdata.size() && $urandom_range(99) >= gap_pct) begin
          data_valid = 1'b1;
          data = wdata[widx];
        end else begin
          data_valid = 1'b0;
          data = $urandom;
        end
        @(negedge clk);
        xfer = data_valid & data_ready;
        @(posedge clk); #1;
        if (xfer) widx++;
        cycles++;
        budget--;
        if (nib <= 2) finished = (done_cnt > base_done);
        else          finished = (err_cnt > base_err);
      end
    end
    fifo_full  = 1'b0;
    data_valid = 1'b0;
    chk({tag, "_timeout"}, {31'h0, finished}, 32'h1);

    repeat (3) @(posedge clk);
    #1;

    if (aborted) begin
      chk({tag, "_abort_words"}, got_q.size(), abort_at);
      chk({tag, "_abort_no_done"}, done_cnt - base_done, 0);
    end else begin
      chk({tag, "_word_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
      chk({tag, "_pkt_done_count"}, done_cnt - base_done, (nib <= 2) ? 1 : 0);
      chk({tag, "_cmd_error_count"}, err_cnt - base_err, (nib <= 2) ? 0 : 1);
      if (nib != 1) chk({tag, "_no_data_ready"}, dr_cnt - base_dr, 0);
      if (full_pct == 0 && gap_pct == 0 && stall_addr == 0 && stall_data == 0 && exp_q.size() > 0)
        chk({tag, "_latency"}, cycles, exp_q.size() + 1);
    end
    chk({tag, "_idle_ready"}, {31'h0, cmd_ready}, 32'h1);
  endtask

  initial begin
    logic [7:0]  rc;
    logic [23:0] rn;
    int sel;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_command = '0;
    cmd_address = '0;
    cmd_data_count = '0;
    data_valid = 1'b0;
    data = '0;
    fifo_full = 1'b0;
    #12;
    chk("reset_cmd_ready",  {31'h0, cmd_ready},  32'h1);
    chk("reset_data_ready", {31'h0, data_ready}, 32'h0);
    chk("reset_fifo_wr",    {31'h0, fifo_wr},    32'h0);
    chk("reset_fifo_data",  fifo_data,           32'h0);
    chk("reset_pkt_done",   {31'h0, pkt_done},   32'h0);
    chk("reset_cmd_error",  {31'h0, cmd_error},  32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_packet("ping",        8'h00, 32'h0000_0000, 24'd5, 0, 0, 0, 0, 0);
    do_packet("read",        8'h02, 32'h0000_1000, 24'd4, 0, 0, 0, 0, 0);
    do_packet("write3",      8'h01, 32'h0000_0010, 24'd3, 0, 0, 0, 0, 0);
    do_packet("write3_gap",  8'h01, 32'h0000_0010, 24'd3, 0, 40, 0, 0, 0);
    do_packet("write3_full", 8'h01, 32'h0000_0010, 24'd3, 0, 0, 5, 3, 0);
    do_packet("bad_cmd",     8'h07, 32'hDEAD_BEEF, 24'd2, 0, 0, 0, 0, 0);
    do_packet("write0",      8'h01, 32'h0000_0020, 24'd0, 0, 0, 0, 0, 0);
    do_packet("write8_rst",  8'h01, 32'h0000_0040, 24'd8, 0, 0, 0, 0, 4);
    do_packet("ping_after",  8'h00, 32'h0000_0000, 24'd9, 0, 0, 0, 0, 0);
    do_packet("ping_hi",     8'hA0, 32'h1234_5678, 24'hFFFFFF, 0, 0, 0, 0, 0);

    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(3);
      rc = 8'($urandom);
      if (sel == 3) begin
        if (rc[3:0] <= 4'h2) rc[3:0] = 4'h3 + 4'($urandom_range(12));
      end else begin
        rc[3:0] = 4'(sel);
      end
      rn = (sel == 1) ? 24'($urandom_range(6)) : 24'($urandom);
      do_packet($sformatf("rand%0d", k), rc, $urandom, rn,
                $urandom_range(40), $urandom_range(50), 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
